// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner. It drives one column low at a time, builds a 16-bit
// scan image, and debounces whole scans into a press strobe and a held level.
module keypad_scanner #(
  parameter int SCAN_DIV       = 50000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);
  localparam int          PW    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PMAX = PW'(SCAN_DIV - 1);
  localparam logic [3:0]  DEB_N = 4'(DEBOUNCE_SCANS);

  typedef enum logic [1:0] {S_IDLE, S_DEB, S_PRS, S_REL} state_t;

  logic [3:0]    sync1_q, sync2_q;
  logic [PW-1:0] pre_q;
  logic [1:0]    col_idx_q, col_nxt;
  logic [3:0]    col_q;
  logic [15:0]   img_q, img_d;
  state_t        state_q;
  logic [3:0]    cnt_q, cnt_inc, cand_q, code_q, key_k;
  logic          vld_q, held_q;
  logic          tick, scan_end, is_none, is_single;

  assign tick     = (pre_q == PMAX);
  assign scan_end = tick && (col_idx_q == 2'd3);
  assign col_nxt  = col_idx_q + 2'd1;
  assign cnt_inc  = (cnt_q == 4'hF) ? cnt_q : cnt_q + 4'd1;

  // Image including this tick's sample, so scan end classifies the full scan.
  always_comb begin
    img_d = img_q;
    img_d[{col_idx_q, 2'b00} +: 4] = ~sync2_q;
  end

  always_comb begin
    key_k = 4'd0;
    for (int i = 0; i < 16; i++)
      if (img_d[i]) key_k = 4'(i);
  end

  assign is_none   = (img_d == 16'd0);
  assign is_single = !is_none && ((img_d & (img_d - 16'd1)) == 16'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q   <= 4'hF;
      sync2_q   <= 4'hF;
      pre_q     <= '0;
      col_idx_q <= 2'd0;
      col_q     <= 4'b1110;
      img_q     <= 16'd0;
      state_q   <= S_IDLE;
      cnt_q     <= 4'd0;
      cand_q    <= 4'd0;
      code_q    <= 4'd0;
      vld_q     <= 1'b0;
      held_q    <= 1'b0;
    end else begin
      sync1_q <= row;
      sync2_q <= sync1_q;
      vld_q   <= 1'b0;
      if (tick) begin
        pre_q     <= '0;
        img_q     <= img_d;
        col_idx_q <= col_nxt;
        col_q     <= ~(4'b0001 << col_nxt);
      end else begin
        pre_q <= pre_q + 1'b1;
      end
      if (scan_end) begin
        unique case (state_q)
          S_IDLE: if (is_single) begin
            cand_q <= key_k;
            cnt_q  <= 4'd1;
            if (DEB_N == 4'd1) begin
              code_q  <= key_k;
              vld_q   <= 1'b1;
              held_q  <= 1'b1;
              state_q <= S_PRS;
            end else begin
              state_q <= S_DEB;
            end
          end
          S_DEB: if (is_single && key_k == cand_q) begin
            cnt_q <= cnt_inc;
            if (cnt_inc >= DEB_N) begin
              code_q  <= cand_q;
              vld_q   <= 1'b1;
              held_q  <= 1'b1;
              state_q <= S_PRS;
            end
          end else begin
            state_q <= S_IDLE;
          end
          // Rollover or MULTI while pressed keeps the original key; no new strobe.
          S_PRS: if (is_none) begin
            cnt_q <= 4'd1;
            if (DEB_N == 4'd1) begin
              held_q  <= 1'b0;
              state_q <= S_IDLE;
            end else begin
              state_q <= S_REL;
            end
          end
          S_REL: if (is_none) begin
            cnt_q <= cnt_inc;
            if (cnt_inc >= DEB_N) begin
              held_q  <= 1'b0;
              state_q <= S_IDLE;
            end
          end else begin
            state_q <= S_PRS;
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign col       = col_q;
  assign key_code  = code_q;
  assign key_valid = vld_q;
  assign key_held  = held_q;
endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: scan-aligned directed key patterns from a table,
// plus hand-written reset sequences.
module tb_keypad_scanner;
  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [3:0] row, col, key_code;
  logic       key_valid, key_held;
  logic [15:0] keys = 16'd0;

  int n_cmp = 0, n_bad = 0, pulses = 0;
  logic prev_v = 1'b0;

  keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_SCANS(2)) dut (
    .clk(clk), .rst_n(rst_n), .row(row), .col(col),
    .key_code(key_code), .key_valid(key_valid), .key_held(key_held)
  );

  always #5 clk = ~clk;

  // Keypad: a pressed key pulls its row low only while its column is driven low.
  always_comb begin
    row = 4'hF;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (!col[c] && keys[c*4+r]) row[r] = 1'b0;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (prev_v) chk("valid_width", {31'd0, key_valid}, 32'd0);
    if (key_valid === 1'b1) pulses++;
    prev_v = (key_valid === 1'b1);
  end

  // Returns just after the edge on which col wraps back to column 0 (scan end).
  task automatic wait_scan();
    bit seen = 0;
    for (int i = 0; i < 64; i++) begin
      @(posedge clk); #1;
      if (col != 4'b1110) seen = 1;
      else if (seen) return;
    end
    chk("scan_timeout", 32'd1, 32'd0);
  endtask

  task automatic run_scans(input int n);
    for (int i = 0; i < n; i++) wait_scan();
    @(negedge clk); #1;
  endtask

  typedef struct {
    logic [15:0] k;
    int          scans;
    int          pulses;
    logic [3:0]  code;
    logic        held;
  } vec_t;

  localparam int NV = 24;
  vec_t tbl [NV];

  initial begin
    tbl[0]  = '{16'h0200, 3, 1, 4'd9,  1'b1};  // clean press key 9
    tbl[1]  = '{16'h0000, 1, 0, 4'd9,  1'b1};
    tbl[2]  = '{16'h0000, 1, 0, 4'd9,  1'b0};
    tbl[3]  = '{16'h0020, 1, 0, 4'd9,  1'b0};  // bounce key 5
    tbl[4]  = '{16'h0000, 1, 0, 4'd9,  1'b0};
    tbl[5]  = '{16'h0020, 1, 0, 4'd9,  1'b0};
    tbl[6]  = '{16'h0000, 1, 0, 4'd9,  1'b0};
    tbl[7]  = '{16'h0020, 1, 0, 4'd9,  1'b0};
    tbl[8]  = '{16'h0000, 1, 0, 4'd9,  1'b0};
    tbl[9]  = '{16'h0020, 1, 0, 4'd9,  1'b0};  // back in IDLE: needs 2 scans
    tbl[10] = '{16'h0020, 1, 1, 4'd5,  1'b1};
    tbl[11] = '{16'h0000, 2, 0, 4'd5,  1'b0};
    tbl[12] = '{16'h8001, 5, 0, 4'd5,  1'b0};  // multi 0+15
    tbl[13] = '{16'h0001, 3, 1, 4'd0,  1'b1};
    tbl[14] = '{16'h0000, 2, 0, 4'd0,  1'b0};
    tbl[15] = '{16'h0008, 2, 1, 4'd3,  1'b1};  // rollover 3 -> 7
    tbl[16] = '{16'h0080, 3, 0, 4'd3,  1'b1};
    tbl[17] = '{16'h0000, 2, 0, 4'd3,  1'b0};
    tbl[18] = '{16'h0080, 2, 1, 4'd7,  1'b1};
    tbl[19] = '{16'h0000, 2, 0, 4'd7,  1'b0};
    tbl[20] = '{16'h1000, 2, 1, 4'd12, 1'b1};  // release glitch on 12
    tbl[21] = '{16'h0000, 1, 0, 4'd12, 1'b1};
    tbl[22] = '{16'h1000, 1, 0, 4'd12, 1'b1};
    tbl[23] = '{16'h1000, 2, 0, 4'd12, 1'b1};

    #3 rst_n = 1'b0;
    #1;
    chk("rst_col",   {28'd0, col}, 32'hE);
    chk("rst_valid", {31'd0, key_valid}, 32'd0);
    chk("rst_held",  {31'd0, key_held}, 32'd0);
    chk("rst_code",  {28'd0, key_code}, 32'd0);
    #20 rst_n = 1'b1;
    run_scans(1);

    for (int v = 0; v < NV; v++) begin
      pulses = 0;
      keys = tbl[v].k;
      run_scans(tbl[v].scans);
      chk($sformatf("v%0d_pulses", v), pulses, tbl[v].pulses);
      chk($sformatf("v%0d_code", v), {28'd0, key_code}, {28'd0, tbl[v].code});
      chk($sformatf("v%0d_held", v), {31'd0, key_held}, {31'd0, tbl[v].held});
    end

    // Mid-press reset with key 12 still down: immediate clear, then column walk.
    rst_n = 1'b0;
    #1;
    chk("mid_rst_col",   {28'd0, col}, 32'hE);
    chk("mid_rst_valid", {31'd0, key_valid}, 32'd0);
    chk("mid_rst_held",  {31'd0, key_held}, 32'd0);
    chk("mid_rst_code",  {28'd0, key_code}, 32'd0);
    @(negedge clk); #2 rst_n = 1'b1;
    pulses = 0;
    for (int k = 1; k <= 16; k++) begin
      logic [3:0] one;
      @(posedge clk); #1;
      one = 4'b0001 << ((k / 4) % 4);
      chk($sformatf("walk_%0d", k), {28'd0, col}, {28'd0, ~one});
    end
    keys = 16'd0;
    run_scans(3);
    chk("after_rst_pulses", pulses, 0);
    chk("after_rst_held", {31'd0, key_held}, 32'd0);

    // Reset in the middle of debouncing key 6.
    pulses = 0;
    keys = 16'h0040;
    run_scans(1);
    rst_n = 1'b0;
    keys = 16'd0;
    #2 rst_n = 1'b1;
    run_scans(3);
    chk("deb_rst_pulses", pulses, 0);
    chk("deb_rst_held", {31'd0, key_held}, 32'd0);
    chk("deb_rst_code", {28'd0, key_code}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
